dm_abstract_cmd: RTL and testbench

Abstract-command sequencer inside the debug module (RISC-V Debug Spec 0.13 "Access Register", cmdtype 0 only). It accepts a command word written over DMI and validates it against hart state. It then drives the core's debug register-access port to move one 32-bit value between data0 and a GPR or CSR. It owns the sticky cmderr field and the busy flag of abstractcs.

---
 rtl/dm_abstract_cmd_pkg.sv | 32 +++
 rtl/dm_abstract_cmd.sv | 142 ++++++++++++++
 tb/tb_dm_abstract_cmd.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_abstract_cmd_pkg.sv
// Shared debug-module definitions: abstractcs.cmderr codes, abstract command
// field positions and the sequencer state type.
package dm_abstract_cmd_pkg;

  localparam logic [2:0] CMDERR_NONE       = 3'd0;
  localparam logic [2:0] CMDERR_BUSY       = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
  localparam logic [2:0] CMDERR_EXCEPT     = 3'd3;
  localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;
  localparam logic [2:0] CMDERR_OTHER      = 3'd7;

  localparam int CMD_TYPE_MSB    = 31;
  localparam int CMD_TYPE_LSB    = 24;
  localparam int CMD_AARSIZE_MSB = 22;
  localparam int CMD_AARSIZE_LSB = 20;
  localparam int CMD_POSTINC     = 19;
  localparam int CMD_POSTEXEC    = 18;
  localparam int CMD_TRANSFER    = 17;
  localparam int CMD_WRITE       = 16;
  localparam int CMD_REGNO_MSB   = 15;

  localparam logic [2:0]  AARSIZE_32  = 3'd2;
  localparam logic [15:0] DM_GPR_BASE = 16'h1000;
  localparam logic [15:0] CSR_LIMIT   = 16'h1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } cmdState_e;

endpackage

// File: rtl/dm_abstract_cmd.sv
// Access Register abstract-command sequencer: validates a DMI command and moves
// one 32-bit value between data0 and a hart GPR/CSR through the debug port.
module dm_abstract_cmd
  import dm_abstract_cmd_pkg::*;
#(
  parameter int          READ_LAT = 1,
  parameter logic [15:0] GPR_BASE = DM_GPR_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CmdValid,
  input  logic [31:0] Command,
  input  logic [31:0] Data0In,
  output logic [31:0] Data0Out,
  output logic        Data0WE,
  input  logic        BusyAccess,
  input  logic [2:0]  CmdErrClr,
  input  logic        DebugMode,
  output logic        DebugControl,
  output logic        RegSel,
  output logic [11:0] RegAddr,
  output logic [31:0] RegWData,
  output logic        DebugRegWrite,
  input  logic [31:0] RegRData,
  output logic        Busy,
  output logic [2:0]  CmdErr,
  output logic        RegnoIncWE,
  output logic [15:0] RegnoInc
);

  localparam logic [2:0] LAT = 3'(READ_LAT);

  cmdState_e   state;
  logic [2:0]  latCnt;
  logic        isWrite;
  logic        incPending;
  logic [15:0] curRegno;
  logic        regSelReg;
  logic [11:0] regAddrReg;
  logic [31:0] wdataReg;

  logic [7:0]  cmdType;
  logic [2:0]  aarSize;
  logic        postInc, postExec, transfer, writeCmd;
  logic [15:0] regno, gprOff;
  logic        isGpr, isCsr, inXfer, readFinal, accept;
  logic [2:0]  newErr, cmdErrNext;
  logic        unusedCmd;

  assign cmdType   = Command[CMD_TYPE_MSB:CMD_TYPE_LSB];
  assign aarSize   = Command[CMD_AARSIZE_MSB:CMD_AARSIZE_LSB];
  assign postInc   = Command[CMD_POSTINC];
  assign postExec  = Command[CMD_POSTEXEC];
  assign transfer  = Command[CMD_TRANSFER];
  assign writeCmd  = Command[CMD_WRITE];
  assign regno     = Command[CMD_REGNO_MSB:0];
  assign unusedCmd = Command[23];

  assign gprOff = regno - GPR_BASE;
  assign isGpr  = (regno >= GPR_BASE) && (gprOff < 16'd32);
  assign isCsr  = regno < CSR_LIMIT;

  // New errors only land on a clear cmderr; a simultaneous W1C loses to them.
  always_comb begin
    newErr = CMDERR_NONE;
    if (state == ST_IDLE) begin
      if (CmdValid && CmdErr == CMDERR_NONE) begin
        if (cmdType != 8'd0 || postExec || (transfer && aarSize != AARSIZE_32))
          newErr = CMDERR_NOTSUP;
        else if (transfer && !isGpr && !isCsr)
          newErr = CMDERR_NOTSUP;
        else if (!DebugMode)
          newErr = CMDERR_HALTRESUME;
      end
    end else if (!DebugMode) begin
      newErr = CMDERR_HALTRESUME;
    end else if (CmdValid || BusyAccess) begin
      newErr = CMDERR_BUSY;
    end
    cmdErrNext = CmdErr & ~CmdErrClr;
    if (CmdErr == CMDERR_NONE && newErr != CMDERR_NONE)
      cmdErrNext = newErr;
  end

  assign accept = (state == ST_IDLE) && CmdValid && (CmdErr == CMDERR_NONE) &&
                  (newErr == CMDERR_NONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      latCnt     <= '0;
      isWrite    <= 1'b0;
      incPending <= 1'b0;
      curRegno   <= '0;
      regSelReg  <= 1'b0;
      regAddrReg <= '0;
      wdataReg   <= '0;
      CmdErr     <= CMDERR_NONE;
    end else begin
      CmdErr <= cmdErrNext;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            latCnt     <= '0;
            isWrite    <= writeCmd;
            incPending <= postInc && transfer;
            curRegno   <= regno;
            regSelReg  <= !isGpr;
            regAddrReg <= isGpr ? {7'b0, gprOff[4:0]} : regno[11:0];
            wdataReg   <= Data0In;
            state      <= transfer ? ST_XFER : ST_DONE;
          end
        end
        ST_XFER: begin
          if (!DebugMode)
            state <= ST_IDLE;
          else if (isWrite || latCnt == LAT)
            state <= ST_DONE;
          else
            latCnt <= latCnt + 3'd1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are qualified by DebugMode so a halt loss cancels them in the same cycle.
  assign inXfer        = (state == ST_XFER);
  assign Busy          = (state != ST_IDLE);
  assign DebugControl  = Busy;
  assign RegSel        = inXfer & regSelReg;
  assign RegAddr       = inXfer ? regAddrReg : 12'd0;
  assign RegWData      = inXfer ? wdataReg : 32'd0;
  assign DebugRegWrite = inXfer & isWrite & DebugMode;
  assign readFinal     = inXfer & ~isWrite & (latCnt == LAT) & DebugMode;
  assign Data0WE       = readFinal;
  assign Data0Out      = readFinal ? RegRData : 32'd0;
  assign RegnoIncWE    = (state == ST_DONE) & incPending & DebugMode;
  assign RegnoInc      = RegnoIncWE ? curRegno + 16'd1 : 16'd0;

endmodule

// File: tb/tb_dm_abstract_cmd.sv
// Scoreboard bench for dm_abstract_cmd: stimulus predicts strobes and cmderr,
// a negedge monitor pops and compares whatever strobes the DUT presents.
module tb_dm_abstract_cmd;
  localparam int          RL = 1;
  localparam logic [15:0] GB = 16'h1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        CmdValid;
  logic [31:0] Command;
  logic [31:0] Data0In;
  logic [31:0] Data0Out;
  logic        Data0WE;
  logic        BusyAccess;
  logic [2:0]  CmdErrClr;
  logic        DebugMode;
  logic        DebugControl;
  logic        RegSel;
  logic [11:0] RegAddr;
  logic [31:0] RegWData;
  logic        DebugRegWrite;
  logic [31:0] RegRData;
  logic        Busy;
  logic [2:0]  CmdErr;
  logic        RegnoIncWE;
  logic [15:0] RegnoInc;

  dm_abstract_cmd #(.READ_LAT(RL), .GPR_BASE(GB)) dut (
    .clk(clk), .reset(reset), .CmdValid(CmdValid), .Command(Command),
    .Data0In(Data0In), .Data0Out(Data0Out), .Data0WE(Data0WE),
    .BusyAccess(BusyAccess), .CmdErrClr(CmdErrClr), .DebugMode(DebugMode),
    .DebugControl(DebugControl), .RegSel(RegSel), .RegAddr(RegAddr),
    .RegWData(RegWData), .DebugRegWrite(DebugRegWrite), .RegRData(RegRData),
    .Busy(Busy), .CmdErr(CmdErr), .RegnoIncWE(RegnoIncWE), .RegnoInc(RegnoInc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          kind;   // 0 core write, 1 data0 load, 2 regno increment
    logic        sel;
    logic [11:0] addr;
    logic [31:0] data;
  } ev_t;
  ev_t expQ[$];

  logic [2:0]  modelErr;
  logic [31:0] mGpr [32];
  logic [31:0] mCsr [4096];

  function automatic logic [31:0] initVal(input bit sel, input int idx);
    return (sel ? 32'hC5A0_0000 : 32'h6B00_0000) ^ (32'(idx) * 32'h0001_0001);
  endfunction

  // Core model: register file with an RL-deep read pipeline.
  logic [31:0] coreGpr [32];
  logic [31:0] coreCsr [4096];
  logic [31:0] rdPipe [RL];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) coreGpr[i] <= initVal(1'b0, i);
      for (int i = 0; i < 4096; i++) coreCsr[i] <= initVal(1'b1, i);
    end else if (DebugRegWrite) begin
      if (RegSel) coreCsr[RegAddr] <= RegWData;
      else coreGpr[RegAddr[4:0]] <= RegWData;
    end
    rdPipe[0] <= RegSel ? coreCsr[RegAddr] : coreGpr[RegAddr[4:0]];
    for (int i = 1; i < RL; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign RegRData = rdPipe[RL-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic popEvent(input int kind);
    ev_t e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_strobe: kind %0d seen, none expected", kind);
    end else begin
      e = expQ.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      if (kind == 0) begin
        chk("wr_sel", 32'(RegSel), 32'(e.sel));
        chk("wr_addr", 32'(RegAddr), 32'(e.addr));
        chk("wr_data", RegWData, e.data);
      end else if (kind == 1) begin
        chk("rd_addr", 32'({RegSel, RegAddr}), 32'({e.sel, e.addr}));
        chk("rd_data0", Data0Out, e.data);
      end else begin
        chk("regno_inc", 32'(RegnoInc), e.data);
      end
    end
  endtask

  // Monitor: independent of stimulus, compares each strobe against the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (!Busy) chk("idle_quiet", 32'({DebugControl, DebugRegWrite, Data0WE, RegnoIncWE}), 32'd0);
      if (DebugRegWrite) popEvent(0);
      if (Data0WE) popEvent(1);
      if (RegnoIncWE) popEvent(2);
    end
  end

  function automatic logic [2:0] validate(input logic [31:0] cmd, input bit dm);
    int r = int'(cmd[15:0]);
    if (cmd[31:24] != 8'd0 || cmd[18] || (cmd[17] && cmd[22:20] != 3'd2)) return 3'd2;
    if (cmd[17] && !((r >= int'(GB) && r < int'(GB) + 32) || r < 4096)) return 3'd2;
    if (!dm) return 3'd4;
    return 3'd0;
  endfunction

  task automatic modelInit();
    for (int i = 0; i < 32; i++) mGpr[i] = initVal(1'b0, i);
    for (int i = 0; i < 4096; i++) mCsr[i] = initVal(1'b1, i);
    modelErr = 3'd0;
  endtask

  task automatic runCmd(input logic [31:0] cmd, input bit dm, input int abortAt,
                        input int disturbAt, input bit disturbIsCmd,
                        input logic [2:0] clr, input logic [31:0] d0);
    logic [2:0]  pre, code;
    int          busyLen, actBusy, ab, c, r;
    bit          gpr;
    logic [11:0] addr;
    ev_t         e;
    pre = modelErr;
    code = validate(cmd, dm);
    modelErr = pre & ~clr;
    busyLen = 0;
    if (pre == 3'd0) begin
      if (code != 3'd0) modelErr = code;
      else busyLen = !cmd[17] ? 1 : (cmd[16] ? 2 : RL + 2);
    end
    ab = (abortAt >= 1 && abortAt <= busyLen) ? abortAt : 0;
    actBusy = (ab != 0) ? ab : busyLen;
    if (busyLen > 0 && cmd[17]) begin
      r = int'(cmd[15:0]);
      gpr = (r >= int'(GB) && r < int'(GB) + 32);
      addr = gpr ? 12'(r - int'(GB)) : cmd[11:0];
      e.sel = !gpr;
      e.addr = addr;
      if (cmd[16] && (ab == 0 || ab > 1)) begin
        e.kind = 0; e.data = d0; expQ.push_back(e);
        if (gpr) mGpr[addr[4:0]] = d0; else mCsr[addr] = d0;
      end
      if (!cmd[16] && (ab == 0 || ab > RL + 1)) begin
        e.kind = 1; e.data = gpr ? mGpr[addr[4:0]] : mCsr[addr]; expQ.push_back(e);
      end
      if (cmd[19] && ab == 0) begin
        e.kind = 2; e.data = 32'(16'(cmd[15:0] + 16'd1)); expQ.push_back(e);
      end
    end
    for (int k = 1; k <= actBusy; k++) begin
      if (k == ab) begin
        if (modelErr == 3'd0) modelErr = 3'd4;
      end else if (k == disturbAt) begin
        if (modelErr == 3'd0) modelErr = 3'd1;
      end
    end
    Command = cmd; DebugMode = dm; Data0In = d0; CmdErrClr = clr; CmdValid = 1'b1;
    @(posedge clk); #1;
    CmdValid = 1'b0; CmdErrClr = 3'd0; Command = $urandom();
    c = 1;
    while (Busy && c <= 20) begin
      if (c == abortAt) DebugMode = 1'b0;
      if (c == disturbAt) begin
        if (disturbIsCmd) CmdValid = 1'b1; else BusyAccess = 1'b1;
      end
      @(posedge clk); #1;
      CmdValid = 1'b0; BusyAccess = 1'b0;
      c++;
    end
    DebugMode = 1'b1;
    chk("busy_cycles", 32'(c - 1), 32'(actBusy));
    chk("cmderr", 32'(CmdErr), 32'(modelErr));
    chk("events_drained", 32'(expQ.size()), 32'd0);
    $display("cmd %h dm %0d abort %0d disturb %0d clr %0d -> busy %0d cmderr %0d",
             cmd, dm, abortAt, disturbAt, clr, c - 1, CmdErr);
    expQ.delete();
    if (Busy) begin
      reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
      modelInit();
    end
  endtask

  task automatic clearErr(input logic [2:0] mask);
    CmdErrClr = mask;
    @(posedge clk); #1;
    CmdErrClr = 3'd0;
    modelErr = modelErr & ~mask;
    chk("cmderr_clear", 32'(CmdErr), 32'(modelErr));
    $display("clear mask %b -> cmderr %0d", mask, CmdErr);
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_flags"}, 32'({Busy, DebugControl, DebugRegWrite, Data0WE, RegnoIncWE, RegSel}), 32'd0);
    chk({tag, "_regaddr"}, 32'(RegAddr), 32'd0);
    chk({tag, "_wdata"}, RegWData, 32'd0);
    chk({tag, "_data0out"}, Data0Out, 32'd0);
    chk({tag, "_regnoinc"}, 32'(RegnoInc), 32'd0);
    chk({tag, "_cmderr"}, 32'(CmdErr), 32'd0);
  endtask

  function automatic logic [31:0] randCmd();
    logic [31:0] cmd;
    logic [15:0] regno;
    int sel = $urandom_range(0, 9);
    if (sel < 5) regno = GB + 16'($urandom_range(0, 31));
    else if (sel < 8) regno = 16'($urandom_range(0, 4095));
    else regno = 16'($urandom_range(32'h1020, 32'hFFFF));
    cmd = 32'd0;
    cmd[31:24] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
    cmd[23]    = 1'($urandom_range(0, 1));
    cmd[22:20] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
    cmd[18]    = ($urandom_range(0, 15) == 0);
    cmd[17]    = ($urandom_range(0, 7) != 0);
    cmd[16]    = 1'($urandom_range(0, 1));
    cmd[19]    = cmd[17] & 1'($urandom_range(0, 1));
    cmd[15:0]  = regno;
    return cmd;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; CmdValid = 1'b0; Command = '0; Data0In = '0;
    BusyAccess = 1'b0; CmdErrClr = '0; DebugMode = 1'b1;
    modelInit();
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b0;

    runCmd(32'h0023_1005, 1, 0, 0, 0, 3'd0, 32'hDEADBEEF);   // write x5
    runCmd(32'h0023_0300, 1, 0, 0, 0, 3'd0, 32'h0000_1800); // mstatus <= 0x1800
    runCmd(32'h0022_0300, 1, 0, 0, 0, 3'd0, 32'h0);         // read it back
    runCmd(32'h002A_100A, 1, 0, 0, 0, 3'd0, 32'h0);         // read x10, postinc
    runCmd(32'h0023_1005, 0, 0, 0, 0, 3'd0, 32'h1234_5678); // not halted
    clearErr(3'b111);
    runCmd(32'h0126_1000, 1, 0, 0, 0, 3'd0, 32'h0);
    clearErr(3'b111);
    runCmd(32'h0024_1000, 1, 0, 0, 0, 3'd0, 32'h0);
    clearErr(3'b111);
    runCmd(32'h0013_1000, 1, 0, 0, 0, 3'd0, 32'h0);
    runCmd(32'h0023_1005, 1, 0, 0, 0, 3'd0, 32'hAAAA_5555); // ignored while cmderr set
    runCmd(32'h0023_1006, 1, 0, 0, 0, 3'b111, 32'h5555_AAAA); // ignored, clear same cycle
    runCmd(32'h0023_101F, 1, 0, 0, 0, 3'd0, 32'h0BAD_F00D); // x31
    runCmd(32'h0022_101F, 1, 0, 0, 0, 3'd0, 32'h0);
    runCmd(32'h0023_1020, 1, 0, 0, 0, 3'd0, 32'h0);         // just past x31
    clearErr(3'b010);
    runCmd(32'h0022_0FFF, 1, 0, 0, 0, 3'd0, 32'h0);         // top CSR
    runCmd(32'h0022_0300, 1, 0, 1, 1, 3'd0, 32'h0);         // second CmdValid mid-read
    clearErr(3'b001);
    runCmd(32'h0023_1007, 1, 0, 2, 0, 3'd0, 32'hCAFE_0007); // BusyAccess in DONE
    clearErr(3'b001);
    runCmd(32'h002A_1007, 1, 2, 0, 0, 3'd0, 32'h0);         // halt lost before data0 load
    clearErr(3'b100);
    runCmd(32'h0020_0000, 1, 0, 0, 0, 3'd0, 32'h0);         // transfer=0

    Command = 32'h0022_0300; Data0In = '0; CmdValid = 1'b1;
    @(posedge clk); #1;
    CmdValid = 1'b0;
    chk("xfer_before_reset", 32'(Busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    checkAllZero("reset_xfer");
    $display("reset during XFER -> busy %0d cmderr %0d", Busy, CmdErr);
    reset = 1'b0;
    modelInit();

    for (int n = 0; n < 250; n++) begin
      runCmd(randCmd(), $urandom_range(0, 9) != 0,
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0,
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0,
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd0,
             $urandom());
      if (modelErr != 3'd0 && $urandom_range(0, 2) != 0) clearErr(3'($urandom_range(1, 7)));
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
